// File: rtl/spike_encoder.sv
// -----------------------------------------------------------------------------
// spike_encoder
//
// Rate-codes eight 8-bit channel intensities into spike trains for a
// neuron array.  A frame has three phases:
//   LOAD : eight intensities are accepted over a valid/ready handshake
//          (channel 0 first).  learn_en is captured with the eighth transfer.
//   RUN  : FRAME_LEN cycles.  Each channel adds its intensity to an 8-bit
//          phase accumulator every cycle, and the carry out is that
//          channel's spike.  Over a frame this yields
//          floor(FRAME_LEN*intensity/256) spikes.
//   DONE : one cycle with frame_done high, then back to LOAD.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous reset, active low
//   in_data    : unsigned channel intensity
//   in_valid   : in_data is valid
//   in_ready   : transfer accepted this cycle when in_valid is also high
//   learn_en   : learn request, sampled with the eighth transfer
//   spikes     : one spike bit per channel, bit i drives neuron input i
//   learn_out  : latched learn request, driven only during RUN
//   busy       : high in RUN and DONE
//   frame_done : one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module spike_encoder #(
    parameter int FRAME_LEN = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       learn_en,
    output logic [0:7] spikes,
    output logic       learn_out,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0] LAST_CYCLE = 9'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] load_idx;
    logic [7:0] intensity [8];
    logic [7:0] acc       [8];
    logic [8:0] sum       [8];
    logic [0:7] carry;
    logic [8:0] frame_cnt;
    logic       learn_latch;
    logic       accept;

    // 9-bit phase sums; the carry bit is the spike for this cycle.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            sum[i]   = {1'b0, acc[i]} + {1'b0, intensity[i]};
            carry[i] = sum[i][8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        spikes     = '0;
        learn_out  = 1'b0;
        accept     = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && load_idx == 3'd7) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                spikes    = carry;
                learn_out = learn_latch;
                if (frame_cnt == LAST_CYCLE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nxt  = LOAD;
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
        // While reset is held the outputs show the idle LOAD view even if
        // the state register has not yet been cleared by a clock edge.
        if (!reset) begin
            in_ready   = 1'b1;
            busy       = 1'b0;
            frame_done = 1'b0;
            spikes     = '0;
            learn_out  = 1'b0;
            accept     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            load_idx    <= 3'd0;
            frame_cnt   <= 9'd0;
            learn_latch <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                intensity[i] <= 8'd0;
                acc[i]       <= 8'd0;
            end
        end else begin
            if (accept) begin
                intensity[load_idx] <= in_data;
                // The 3-bit index wraps to 0 after channel 7.
                load_idx <= load_idx + 3'd1;
                if (load_idx == 3'd7) begin
                    learn_latch <= learn_en;
                end
            end
            // Accumulators and counter are held at zero outside RUN so every
            // frame starts from phase 0.
            if (state == RUN) begin
                frame_cnt <= frame_cnt + 9'd1;
                for (int i = 0; i < 8; i++) begin
                    acc[i] <= sum[i][7:0];
                end
            end else begin
                frame_cnt <= 9'd0;
                for (int i = 0; i < 8; i++) begin
                    acc[i] <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_encoder
//
// Bench for spike_encoder.  A behavioural model tracks which phase of the
// frame the block is in and which intensities were loaded, and predicts each
// channel's spike on RUN cycle t as the step in floor(t*I/256).  A compare
// process checks every output on every falling edge; directed scenarios add
// literal spike/busy/learn/frame_done totals.
// -----------------------------------------------------------------------------
module tb_spike_encoder;

    localparam int FL = 256;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] in_data  = 8'd0;
    logic       in_valid = 1'b0;
    logic       learn_en = 1'b0;
    logic       in_ready;
    logic [0:7] spikes;
    logic       learn_out;
    logic       busy;
    logic       frame_done;

    spike_encoder #(.FRAME_LEN(FL)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .learn_en   (learn_en),
        .spikes     (spikes),
        .learn_out  (learn_out),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=loading, 1=running, 2=done
    int m_phase = 0;
    int m_cnt   = 0;
    int m_t     = 0;
    int m_int [8] = '{default: 0};
    bit m_learn = 1'b0;

    // Totals observed from the DUT
    int sp_cnt [8] = '{default: 0};
    int busy_cnt  = 0;
    int fd_cnt    = 0;
    int learn_cnt = 0;

    int v [8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit exp_spike(input int i);
        return (((m_t + 1) * m_int[i]) / 256) != ((m_t * m_int[i]) / 256);
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_t     = 0;
            m_learn = 1'b0;
            for (int i = 0; i < 8; i++) m_int[i] = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_int[m_cnt] = int'(in_data);
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt   = 0;
                        m_learn = learn_en;
                        m_phase = 1;
                        m_t     = 0;
                    end
                end
                1: if (m_t == FL - 1) m_phase = 2; else m_t++;
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [0:7] es;
        for (int i = 0; i < 8; i++) es[i] = reset && m_phase == 1 && exp_spike(i);
        check("in_ready",   int'(in_ready),   int'(!reset || m_phase == 0));
        check("busy",       int'(busy),       int'(reset && m_phase != 0));
        check("frame_done", int'(frame_done), int'(reset && m_phase == 2));
        check("learn_out",  int'(learn_out),  int'(reset && m_phase == 1 && m_learn));
        check("spikes",     int'(spikes),     int'(es));
        for (int i = 0; i < 8; i++) if (spikes[i]) sp_cnt[i]++;
        if (busy) busy_cnt++;
        if (frame_done) fd_cnt++;
        if (learn_out) learn_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 8; i++) sp_cnt[i] = 0;
        busy_cnt  = 0;
        fd_cnt    = 0;
        learn_cnt = 0;
    endtask

    task automatic load8(input int vals [8], input bit le, input int gap_max);
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_data  = 8'(vals[k]);
            learn_en = (k == 7) ? le : 1'($urandom_range(1, 0));
            step();
        end
        in_valid = 1'b0;
        learn_en = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 0; n < 2000 && !seen; n++) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        if (!seen) check("frame_done timeout", 0, 1);
        step();
    endtask

    task automatic check_counts(input string name);
        for (int i = 0; i < 8; i++) check(name, sp_cnt[i], (FL * v[i]) / 256);
    endtask

    initial begin
        // Reset held for several cycles, then released
        reset = 1'b0;
        repeat (3) step();
        check("rst in_ready", int'(in_ready), 1);
        check("rst busy", int'(busy), 0);
        reset = 1'b1;
        step();
        check("post-rst in_ready", int'(in_ready), 1);
        check("post-rst spikes", int'(spikes), 0);
        check("post-rst learn_out", int'(learn_out), 0);

        // Mixed intensities
        v = '{0, 1, 64, 128, 200, 255, 255, 17};
        clear_counts();
        load8(v, 1'b0, 2);
        wait_done();
        check("mix ch0", sp_cnt[0], 0);
        check("mix ch1", sp_cnt[1], 1);
        check("mix ch2", sp_cnt[2], 64);
        check("mix ch3", sp_cnt[3], 128);
        check("mix ch4", sp_cnt[4], 200);
        check("mix ch5", sp_cnt[5], 255);
        check("mix ch6", sp_cnt[6], 255);
        check("mix ch7", sp_cnt[7], 17);
        check("mix busy cycles", busy_cnt, 257);
        check("mix frame_done pulses", fd_cnt, 1);

        // Single channel at half rate
        v = '{0, 0, 0, 128, 0, 0, 0, 0};
        clear_counts();
        load8(v, 1'b0, 0);
        wait_done();
        check("half ch3", sp_cnt[3], 128);
        check("half others", sp_cnt[0] + sp_cnt[1] + sp_cnt[2] + sp_cnt[4] +
                             sp_cnt[5] + sp_cnt[6] + sp_cnt[7], 0);

        // Learn request on the final transfer
        v = '{10, 20, 30, 40, 50, 60, 70, 80};
        clear_counts();
        load8(v, 1'b1, 1);
        wait_done();
        check("learn cycles", learn_cnt, 256);
        check_counts("learn counts");

        // in_valid held through RUN with changing data
        v = '{3, 99, 150, 7, 250, 33, 128, 1};
        clear_counts();
        load8(v, 1'b0, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 2000 && !seen; n++) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                step();
                if (frame_done) seen = 1'b1;
            end
            if (!seen) check("busy-valid timeout", 0, 1);
            in_valid = 1'b0;
            step();
        end
        check_counts("busy-valid counts");
        check("busy-valid frame_done", fd_cnt, 1);

        // Reset during a partial load
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(200 + k);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("partial frame_done", fd_cnt, 0);
        v = '{11, 22, 33, 44, 55, 66, 77, 88};
        clear_counts();
        load8(v, 1'b0, 1);
        wait_done();
        check_counts("after partial counts");

        // Reset at RUN cycle 100
        v = '{255, 128, 64, 32, 16, 8, 4, 2};
        clear_counts();
        load8(v, 1'b1, 0);
        repeat (100) step();
        reset = 1'b0;
        step();
        check("midrun spikes", int'(spikes), 0);
        check("midrun busy", int'(busy), 0);
        check("midrun in_ready", int'(in_ready), 1);
        reset = 1'b1;
        step();
        check("midrun frame_done", fd_cnt, 0);
        v = '{5, 0, 250, 100, 1, 2, 3, 129};
        clear_counts();
        load8(v, 1'b0, 0);
        wait_done();
        check_counts("after midrun counts");

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(255, 0));
            clear_counts();
            load8(v, 1'($urandom_range(1, 0)), 3);
            wait_done();
            check_counts("random counts");
            check("random busy cycles", busy_cnt, FL + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
